gpnae_core: RTL and testbench

//  General-purpose nonlinear activation engine. Buffers IEEE-754 single-precision samples in an

---
 rtl/gpnae_core.sv | 199 +++++++++++++++++++
 tb/tb_gpnae_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpnae_core.sv
// gpnae_core: FIFO-buffered FP32 activation engine (SELU / sigmoid / tanh).
// Samples are queued while idle. A start request then walks the queue one entry
// at a time through FETCH -> TOFIX -> EVAL -> TOFLT -> EMIT, giving one result
// every five cycles.
module gpnae_core #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_LINES    = 5,
    parameter int CONTROL_WIDTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [DATA_WIDTH-1:0]    signal_i,
    input  logic                     wr_en_i,
    input  logic                     last_i,
    input  logic [ADDR_LINES-1:0]    terms_i,
    input  logic [CONTROL_WIDTH-1:0] control_word_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     idle_o,
    output logic [DATA_WIDTH-1:0]    final_result_o,
    output logic                     done_o
);

    localparam int                  DEPTH   = 1 << ADDR_LINES;
    localparam logic [ADDR_LINES:0] DEPTH_C = (ADDR_LINES + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_TOFIX, S_EVAL, S_TOFLT, S_EMIT} state_t;

    state_t                   r_state, w_next;
    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
    logic [ADDR_LINES-1:0]    r_wr_ptr, r_rd_ptr;
    logic [ADDR_LINES:0]      r_count, r_left, w_count_eff, w_terms;
    logic [CONTROL_WIDTH-1:0] r_ctrl;
    logic                     w_push, w_pop, w_start;
    logic [DATA_WIDTH-1:0]    r_sample_p0;
    logic signed [31:0]       r_fix_p1, r_act_p2;

    // FP32 -> signed Q8.16, round-to-nearest; |x|>=128, Inf and NaN saturate by sign.
    function automatic logic signed [31:0] fp_to_fix(input logic [31:0] f);
        logic [7:0]         e;
        logic [32:0]        mant;
        logic signed [31:0] mag, res;
        int                 sh;
        e    = f[30:23];
        mant = {9'd0, 1'b1, f[22:0]};
        sh   = 134 - int'(e);
        if (e == 8'd0) begin
            res = '0;
        end else if (e >= 8'd134) begin
            res = f[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end else begin
            if (sh > 25) mag = '0;
            else         mag = signed'(32'((mant + (33'd1 << (sh - 1))) >> sh));
            res = f[31] ? -mag : mag;
        end
        return res;
    endfunction

    // Piecewise-linear sigmoid on a non-negative Q16 magnitude.
    function automatic logic [31:0] plan_sig(input logic [32:0] a);
        logic [31:0] y;
        if (a >= 33'd327680)      y = 32'd65536;
        else if (a >= 33'd155648) y = 32'(a >> 5) + 32'd55296;
        else if (a >= 33'd65536)  y = 32'(a >> 3) + 32'd40960;
        else                      y = 32'(a >> 2) + 32'd32768;
        return y;
    endfunction

    // Activation in Q8.16; SELU's negative side uses e^x = 2^(x*log2e) with a linear 2^f.
    function automatic logic signed [31:0] act_eval(input logic [1:0] ctrl,
                                                    input logic signed [31:0] x);
        logic [32:0]        ax;
        logic signed [63:0] xs, p, t, q;
        logic [31:0]        s, ex;
        logic signed [31:0] y, th, em1;
        logic [15:0]        fr;
        int                 sh;
        ax = x[31] ? (33'd0 - {1'b1, x}) : {1'b0, x};
        xs = 64'(x);
        y  = '0;
        case (ctrl)
            2'b01: begin
                if (!x[31] && x != 0) begin
                    p = (xs * 64'sd68858) >>> 16;
                    y = (p > 64'sd2147483647) ? 32'sh7FFF_FFFF : 32'(p);
                end else if (x < -32'sd1048576) begin
                    y = -32'sd115219;
                end else begin
                    t   = (xs * 64'sd94548) >>> 16;
                    sh  = -int'(t >>> 16);
                    fr  = 16'(t);
                    ex  = (32'd65536 + {16'd0, fr}) >> sh;
                    em1 = signed'(ex) - 32'sd65536;
                    q   = (64'(em1) * 64'sd115219) >>> 16;
                    y   = 32'(q);
                end
            end
            2'b10: begin
                s = plan_sig(ax);
                y = x[31] ? signed'(32'd65536 - s) : signed'(s);
            end
            2'b11: begin
                s  = plan_sig(ax << 1);
                th = signed'((s << 1) - 32'd65536);
                y  = x[31] ? -th : th;
            end
            default: y = '0;
        endcase
        return y;
    endfunction

    // Signed Q8.16 -> FP32 by locating the leading one; mantissa is truncated.
    function automatic logic [31:0] fix_to_fp(input logic signed [31:0] v);
        logic [31:0] mag, r;
        logic [22:0] m;
        int          p;
        mag = v[31] ? 32'(-v) : 32'(v);
        p   = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        if (p >= 23) m = 23'(mag >> (p - 23));
        else         m = 23'(mag << (23 - p));
        r = (v == 0) ? 32'd0 : {v[31], 8'(127 + p - 16), m};
        return r;
    endfunction

    assign full_o      = (r_count == DEPTH_C);
    assign empty_o     = (r_count == '0);
    assign idle_o      = (r_state == S_IDLE) && !full_o;
    assign done_o      = (r_state == S_EMIT);
    assign w_push      = wr_en_i && idle_o;
    assign w_pop       = (r_state == S_FETCH);
    // A write in the start cycle is counted toward the run.
    assign w_count_eff = r_count + {{ADDR_LINES{1'b0}}, w_push};
    assign w_start     = (r_state == S_IDLE) && last_i && (w_count_eff != '0)
                         && (control_word_i != '0);
    assign w_terms     = (terms_i == '0 || {1'b0, terms_i} > w_count_eff)
                         ? w_count_eff : {1'b0, terms_i};

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state: five-state loop per entry, back to IDLE after the last EMIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_FETCH;
            S_FETCH: w_next = S_TOFIX;
            S_TOFIX: w_next = S_EVAL;
            S_EVAL:  w_next = S_TOFLT;
            S_TOFLT: w_next = S_EMIT;
            S_EMIT:  w_next = (r_left == '0) ? S_IDLE : S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    // FIFO pointers/occupancy and the per-run latched control word and entry budget.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_left   <= '0;
            r_ctrl   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            if (w_start) begin
                r_ctrl <= control_word_i;
                r_left <= w_terms;
            end else if (w_pop) begin
                r_left <= r_left - 1'b1;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= signal_i;
    end

    // Datapath stages: fetch, convert to fixed, evaluate.
    always_ff @(posedge clk_i) begin
        if (r_state == S_FETCH) r_sample_p0 <= r_mem[r_rd_ptr];
        if (r_state == S_TOFIX) r_fix_p1    <= fp_to_fix(r_sample_p0);
        if (r_state == S_EVAL)  r_act_p2    <= act_eval(r_ctrl, r_fix_p1);
    end

    // Result register, updated only in TOFLT so it is stable while done_o is high.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                 final_result_o <= '0;
        else if (r_state == S_TOFLT) final_result_o <= fix_to_fp(r_act_p2);
    end

endmodule

// File: tb/tb_gpnae_core.sv
// Directed bench for gpnae_core: reset, sigmoid/tanh sweeps, SELU points,
// FIFO full/drop, mid-run reset and partial runs via terms_i.
module tb_gpnae_core;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b1;
    logic [31:0] signal_i = '0;
    logic        wr_en_i = 1'b0;
    logic        last_i = 1'b0;
    logic [4:0]  terms_i = '0;
    logic [1:0]  control_word_i = '0;
    logic        full_o, empty_o, idle_o, done_o;
    logic [31:0] final_result_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] res [0:63];
    int          rcyc [0:63];
    int          nres;
    logic [31:0] smp [0:29];
    int          ndone;

    always #5 clk = ~clk;

    gpnae_core dut (
        .clk_i          (clk),
        .rstn_i         (rstn_i),
        .signal_i       (signal_i),
        .wr_en_i        (wr_en_i),
        .last_i         (last_i),
        .terms_i        (terms_i),
        .control_word_i (control_word_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .idle_o         (idle_o),
        .final_result_o (final_result_o),
        .done_o         (done_o)
    );

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [31:0] f;
        b = $realtobits(r);
        if (r == 0.0) f = 32'd0;
        else          f = {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
        return f;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:0] == 31'd0) return 0.0;
        b = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic real sig_ideal(input real x);
        return 1.0 / (1.0 + $exp(-x));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic [31:0] obs, input real ideal,
                           input real tol);
        real o, d;
        o = f2r(obs);
        d = o - ideal;
        if (d < 0.0) d = -d;
        checks++;
        assert (d <= tol) else begin
            failures++;
            $error("FAIL %s observed=%f expected=%f tol=%f", tag, o, ideal, tol);
        end
    endtask

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        signal_i = w;
        wr_en_i  = 1'b1;
        @(negedge clk);
        wr_en_i  = 1'b0;
    endtask

    // Start a run, then scramble control/terms to show they were latched.
    task automatic run(input int n_exp, input logic [1:0] ctrl, input logic [4:0] terms,
                       input string tag);
        nres = 0;
        @(negedge clk);
        control_word_i = ctrl;
        terms_i        = terms;
        last_i         = 1'b1;
        for (int c = 1; c <= 5 * n_exp + 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin
                last_i         = 1'b0;
                control_word_i = 2'b00;
                terms_i        = 5'd1;
            end
            if (done_o) begin
                if (nres < 64) begin
                    res[nres]  = final_result_o;
                    rcyc[nres] = c;
                end
                nres++;
            end
        end
        chk({tag, " count"}, 32'(nres), 32'(n_exp));
        for (int k = 0; k < n_exp && k < nres && k < 64; k++)
            chk($sformatf("%s t%0d", tag, k), 32'(rcyc[k]), 32'(5 * (k + 1)));
    endtask

    initial begin
        // Reset state
        #1 rstn_i = 1'b0;
        #21;
        chk("rst full", {31'd0, full_o}, 32'd0);
        chk("rst empty", {31'd0, empty_o}, 32'd1);
        chk("rst idle", {31'd0, idle_o}, 32'd1);
        chk("rst done", {31'd0, done_o}, 32'd0);
        chk("rst result", final_result_o, 32'd0);
        @(negedge clk);
        rstn_i = 1'b1;

        // Sigmoid sweep -5..5
        for (int i = 0; i < 15; i++) begin
            smp[i]      = r2f(-5.0 + i * 10.0 / 29.0);
            smp[29 - i] = smp[i] ^ 32'h8000_0000;
        end
        chk("sig in0", smp[0], 32'hC0A0_0000);
        for (int i = 0; i < 30; i++) push(smp[i]);
        chk("sig empty", {31'd0, empty_o}, 32'd0);
        run(30, 2'b10, 5'd0, "sig");
        chk("sig r0", res[0], 32'h0000_0000);
        chk("sig r29", res[29], 32'h3F80_0000);
        for (int i = 0; i < 30; i++)
            chk_tol($sformatf("sig err%0d", i), res[i], sig_ideal(f2r(smp[i])), 0.02);
        chk("sig empty after", {31'd0, empty_o}, 32'd1);

        // Tanh sweep -10..10
        for (int i = 0; i < 15; i++) begin
            smp[i]      = r2f(-10.0 + i * 20.0 / 29.0);
            smp[29 - i] = smp[i] ^ 32'h8000_0000;
        end
        for (int i = 0; i < 30; i++) push(smp[i]);
        run(30, 2'b11, 5'd0, "tanh");
        chk("tanh r0", res[0], 32'hBF80_0000);
        chk("tanh r29", res[29], 32'h3F80_0000);
        for (int i = 0; i < 15; i++)
            chk($sformatf("tanh sym%0d", i), res[29 - i], res[i] ^ 32'h8000_0000);
        for (int i = 0; i < 30; i++)
            chk_tol($sformatf("tanh err%0d", i), res[i],
                    2.0 * sig_ideal(2.0 * f2r(smp[i])) - 1.0, 0.04);

        // SELU at +5 and -5
        push(32'h40A0_0000);
        push(32'hC0A0_0000);
        run(2, 2'b01, 5'd0, "selu");
        chk("selu pos", res[0], 32'h40A8_1C40);
        chk("selu neg", res[1], 32'hBFDF_7800);
        chk_tol("selu pos rel", res[0], 5.0 * 1.0507009873554805,
                5.0 * 1.0507009873554805 / 4096.0);
        chk_tol("selu neg abs", res[1], 1.7580993408473766 * ($exp(-5.0) - 1.0), 0.11);

        // FIFO full boundary and dropped 33rd write
        for (int i = 0; i < 31; i++) push(32'h0000_0000);
        chk("fifo 31 full", {31'd0, full_o}, 32'd0);
        chk("fifo 31 idle", {31'd0, idle_o}, 32'd1);
        push(32'h0000_0000);
        chk("fifo 32 full", {31'd0, full_o}, 32'd1);
        chk("fifo 32 idle", {31'd0, idle_o}, 32'd0);
        push(32'h40A0_0000);
        chk("fifo 33 full", {31'd0, full_o}, 32'd1);
        run(32, 2'b10, 5'd0, "fifo");
        for (int k = 0; k < 32; k++)
            chk($sformatf("fifo r%0d", k), res[k], 32'h3F00_0000);
        chk("fifo empty after", {31'd0, empty_o}, 32'd1);

        // Reset in the middle of a run
        for (int i = 0; i < 4; i++) push(32'h40A0_0000);
        @(negedge clk);
        control_word_i = 2'b10;
        terms_i        = 5'd0;
        last_i         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        last_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid done before", {31'd0, done_o}, 32'd1);
        chk("mid result before", final_result_o, 32'h3F80_0000);
        rstn_i = 1'b0;
        #1;
        chk("mid done", {31'd0, done_o}, 32'd0);
        chk("mid empty", {31'd0, empty_o}, 32'd1);
        chk("mid idle", {31'd0, idle_o}, 32'd1);
        chk("mid result", final_result_o, 32'd0);
        @(negedge clk);
        rstn_i = 1'b1;
        ndone  = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        chk("mid no results", 32'(ndone), 32'd0);

        // Partial run: terms_i=3 of 5 entries, then drain the remaining 2
        push(32'h40A0_0000);
        push(32'hC0A0_0000);
        push(32'h0000_0000);
        push(32'h40A0_0000);
        push(32'hC0A0_0000);
        run(3, 2'b01, 5'd3, "part");
        chk("part r0", res[0], 32'h40A8_1C40);
        chk("part r1", res[1], 32'hBFDF_7800);
        chk("part r2", res[2], 32'h0000_0000);
        chk("part empty", {31'd0, empty_o}, 32'd0);
        run(2, 2'b01, 5'd0, "rest");
        chk("rest r0", res[0], 32'h40A8_1C40);
        chk("rest r1", res[1], 32'hBFDF_7800);
        chk("rest empty", {31'd0, empty_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
